// File: rtl/anti_rebote_pkg.sv
// Shared types and default tuning for the push-button debouncer.
package anti_rebote_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/anti_rebote_sync_ff.sv
// N-stage flop chain bringing an asynchronous level into the clk domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the raw level through the chain every cycle, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/anti_rebote.sv
// Debounces the raw button `bot` and emits a one-cycle pulse on Y per clean press.
module anti_rebote
  import anti_rebote_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic bot,
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic Y
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             y_r, rise_s, deb_s, s_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bot),
    .q   (s_s)
  );

  // Debounced level is implied by which half of the state space we are in.
  always_comb begin
    deb_s = 1'b0;
    case (state_r)
      IDLE_HIGH, CHK_LOW: deb_s = 1'b1;
      default:            deb_s = 1'b0;
    endcase
  end

  // Next-state, stability counter and press detection.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    rise_s      = 1'b0;
    if (!en) begin
      // Frozen: no counting, debounced level held.
      cnt_nxt_s   = '0;
      state_nxt_s = deb_s ? IDLE_HIGH : IDLE_LOW;
    end else if (s_s == deb_s) begin
      cnt_nxt_s   = '0;
      state_nxt_s = deb_s ? IDLE_HIGH : IDLE_LOW;
    end else if (cnt_r < CNT_MAX) begin
      cnt_nxt_s   = cnt_r + CNT_W'(1);
      state_nxt_s = deb_s ? CHK_LOW : CHK_HIGH;
    end else begin
      cnt_nxt_s   = '0;
      state_nxt_s = deb_s ? IDLE_LOW : IDLE_HIGH;
      rise_s      = ~deb_s;
    end
  end

  // State, counter and output pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE_LOW;
      cnt_r   <= '0;
      y_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      y_r     <= rise_s;
    end
  end

  assign Y = y_r;

endmodule

// File: tb/tb_anti_rebote.sv
// Randomised and directed bench for anti_rebote against a sliding-window reference model.
module tb_anti_rebote;

  localparam int NS = 2;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst, bot, en, Y;

  int checks = 0;
  int errors = 0;

  // Reference model: bot samples in flight, and last NC edges of (s, en).
  bit sync_q[$];
  bit s_q[$];
  bit en_q[$];
  bit m_deb;
  bit exp_y;

  anti_rebote dut (.bot(bot), .clk(clk), .rst(rst), .en(en), .Y(Y));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sync_q.delete(); s_q.delete(); en_q.delete();
    for (int i = 0; i < NS; i++) sync_q.push_back(1'b0);
    for (int i = 0; i < NC; i++) begin
      s_q.push_back(1'b0);
      en_q.push_back(1'b0);
    end
    m_deb = 1'b0;
    exp_y = 1'b0;
  endtask

  // A level flips once the last NC enabled edges all disagreed with it.
  task automatic model_edge(input bit b, input bit e);
    bit s, all;
    s = sync_q.pop_front();
    sync_q.push_back(b);
    s_q.push_back(s);
    en_q.push_back(e);
    void'(s_q.pop_front());
    void'(en_q.pop_front());
    all = 1'b1;
    for (int i = 0; i < NC; i++)
      if (!en_q[i] || s_q[i] == m_deb) all = 1'b0;
    exp_y = all && !m_deb;
    if (all) m_deb = ~m_deb;
  endtask

  task automatic step(input bit b, input bit e);
    bot = b;
    en  = e;
    @(posedge clk);
    model_edge(b, e);
    #1;
    check("model_y", Y, exp_y);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    check("rst_y_now", Y, 0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_y_held", Y, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int pulses;
  int run;
  bit rb, re;

  initial begin
    rst = 1'b1; bot = 1'b1; en = 1'b1;
    model_reset();
    #1;
    check("reset_y_t0", Y, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_y", Y, 0);
      check("reset_cnt", dut.cnt_r, 0);
      check("reset_deb", dut.deb_s, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Clean press: pulse only after edge 6, none while held.
    pulses = 0;
    for (int i = 1; i <= 14; i++) begin
      step(1'b1, 1'b1);
      check("press_lat", Y, (i == 6) ? 1 : 0);
      pulses += Y;
    end
    // Release then second press.
    for (int i = 0; i < 10; i++) begin step(1'b0, 1'b1); pulses += Y; end
    check("release_nopulse", pulses, 1);
    for (int i = 0; i < 10; i++) begin step(1'b1, 1'b1); pulses += Y; end
    check("two_presses", pulses, 2);

    // Enable gating with sync already full.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin step(1'b1, 1'b0); pulses += Y; end
    check("en_off_nopulse", pulses, 0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b1);
      check("en_lat", Y, (i == 4) ? 1 : 0);
    end

    // Bounce: high runs shorter than the stability window.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    pulses = 0;
    for (int r = 0; r < 12; r++) begin
      run = 1 + (r % 3);
      for (int k = 0; k < run; k++) begin step(r[0] ? 1'b0 : 1'b1, 1'b1); pulses += Y; end
    end
    check("bounce_nopulse", pulses, 0);
    check("bounce_deb", dut.deb_s, 0);

    // Reset mid-count, button still held afterwards.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin step(1'b1, 1'b1); pulses += Y; end
    check("premid_nopulse", pulses, 0);
    async_reset();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1);
      check("post_rst_lat", Y, (i == 6) ? 1 : 0);
    end

    // Reset in the middle of a pulse.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    check("pulse_before_rst", Y, 1);
    async_reset();

    // Random run-length stimulus with occasional enable drops and resets.
    run = 0;
    rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        rb  = ~rb;
        run = $urandom_range(1, 9);
      end
      run--;
      re = ($urandom_range(0, 9) != 0);
      step(rb, re);
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
